// File: rtl/soc_timer_responder_if.sv
// Peripheral-bus bundle between the CPU bus fabric and the TIMER0 responder.
// The fabric drives a request (valid/addr/wdata/wmask) and the responder
// answers with a one-cycle ready strobe carrying registered read data.
interface soc_timer_responder_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid,
    output addr,
    output wdata,
    output wmask,
    input  rdata,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  wdata,
    input  wmask,
    output rdata,
    output ready
  );
endinterface

// File: rtl/soc_timer_responder.sv
// TIMER0 bus responder: decodes CPU load/store accesses inside a 4 KiB window
// and owns a 64-bit up-counter with prescaler, a 32-bit compare register and
// a maskable level interrupt.
//
// Register map (exact match on addr[7:0]):
//   0x00 CONFIG      [0] en, [1] auto_clr, [2] irq_en, [3] pend (write 1 to clear),
//                    [8 +: PRESC_W] presc
//   0x08 COUNTER_MSB cnt[63:32]
//   0x10 COUNTER_LSB cnt[31:0]
//   0x12 SCALED      live prescaler count, read-only
//   0x20 COMPARE     compared against cnt[31:0] on every tick
// Any other offset reads as zero, ignores writes and is still acknowledged.
//
// Optional build macro TIMER_LATCH_MSB_EN: a COUNTER_LSB read snapshots
// cnt[63:32] into a shadow register and COUNTER_MSB reads return that
// snapshot, so software reading LSB then MSB sees a consistent 64-bit value.
// Without the macro COUNTER_MSB reads the live upper half.
module soc_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hffff_f000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  soc_timer_responder_if.slave bus,
  output logic                 irq
);

  localparam logic [7:0] OFF_CONFIG  = 8'h00;
  localparam logic [7:0] OFF_CNT_MSB = 8'h08;
  localparam logic [7:0] OFF_CNT_LSB = 8'h10;
  localparam logic [7:0] OFF_SCALED  = 8'h12;
  localparam logic [7:0] OFF_COMPARE = 8'h20;

  // Bytes of CONFIG that hold prescaler bits; touching any of them restarts psc.
  localparam logic [3:0] PRESC_BYTES = (PRESC_W > 8) ? 4'b0110 : 4'b0010;

  // Timer state
  logic               en;
  logic               auto_clr;
  logic               irq_en;
  logic               pend;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] psc;
  logic [63:0]        cnt;
  logic [31:0]        compare;

  // Bus response registers
  logic               rsp_ready;
  logic [31:0]        rsp_data;

  // Decode and per-register byte enables
  logic               hit;
  logic               wr_req;
  logic               rd_req;
  logic [7:0]         offset;
  logic [3:0]         be_cfg;
  logic [3:0]         be_msb;
  logic [3:0]         be_lsb;
  logic [3:0]         be_cmp;

  // Next-state values
  logic               tick;
  logic               match;
  logic [PRESC_W-1:0] psc_next;
  logic [PRESC_W-1:0] presc_next;
  logic [PRESC_W-1:0] presc_we;
  logic [63:0]        cnt_tick;
  logic [63:0]        cnt_next;
  logic [31:0]        compare_next;
  logic               en_next;
  logic               auto_clr_next;
  logic               irq_en_next;
  logic               pend_next;
  logic [31:0]        rd_value;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] bit_we;
    bit_we = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_word & ~bit_we) | (new_word & bit_we);
  endfunction

  // Accept a request only in our window and never while a response is on the bus,
  // so a held request is answered every second cycle.
  always_comb begin
    hit    = bus.valid & ((bus.addr & ADDR_MASK) == BASE_ADDR) & ~rsp_ready;
    offset = bus.addr[7:0];
    wr_req = hit & (|bus.wmask);
    rd_req = hit & ~(|bus.wmask);
    be_cfg = (wr_req && offset == OFF_CONFIG)  ? bus.wmask : 4'b0000;
    be_msb = (wr_req && offset == OFF_CNT_MSB) ? bus.wmask : 4'b0000;
    be_lsb = (wr_req && offset == OFF_CNT_LSB) ? bus.wmask : 4'b0000;
    be_cmp = (wr_req && offset == OFF_COMPARE) ? bus.wmask : 4'b0000;
  end

`ifdef TIMER_LATCH_MSB_EN
  logic [31:0] shadow;
  logic [31:0] shadow_next;

  // Snapshot the upper half on an LSB read; a direct MSB write also lands here.
  always_comb begin
    shadow_next = shadow;
    if (rd_req && offset == OFF_CNT_LSB) shadow_next = cnt[63:32];
    if (|be_msb) shadow_next = merge_bytes(shadow, bus.wdata, be_msb);
  end

  // Shadow register for atomic 64-bit reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= '0;
    else     shadow <= shadow_next;
  end
`endif

  // Read mux sampled from the current (pre-write) state of the accept cycle.
  always_comb begin
    rd_value = '0;
    case (offset)
      OFF_CONFIG: begin
        rd_value[0]            = en;
        rd_value[1]            = auto_clr;
        rd_value[2]            = irq_en;
        rd_value[3]            = pend;
        rd_value[8 +: PRESC_W] = presc;
      end
`ifdef TIMER_LATCH_MSB_EN
      OFF_CNT_MSB: rd_value = shadow;
`else
      OFF_CNT_MSB: rd_value = cnt[63:32];
`endif
      OFF_CNT_LSB: rd_value = cnt[31:0];
      OFF_SCALED:  rd_value[PRESC_W-1:0] = psc;
      OFF_COMPARE: rd_value = compare;
      default:     rd_value = '0;
    endcase
  end

  // Prescaler, counter and pending-flag update with bus writes layered on top.
  always_comb begin
    tick     = 1'b0;
    psc_next = psc;
    if (en) begin
      if (psc == presc) begin
        psc_next = '0;
        tick     = 1'b1;
      end else begin
        psc_next = psc + PRESC_W'(1);
      end
    end

    match    = tick & (cnt[31:0] == compare);
    cnt_tick = cnt;
    if (tick) cnt_tick = (match && auto_clr) ? 64'd0 : cnt + 64'd1;

    // Written counter bytes win over the tick result; unwritten bytes keep it.
    cnt_next     = {merge_bytes(cnt_tick[63:32], bus.wdata, be_msb),
                    merge_bytes(cnt_tick[31:0],  bus.wdata, be_lsb)};
    compare_next = merge_bytes(compare, bus.wdata, be_cmp);

    en_next       = be_cfg[0] ? bus.wdata[0] : en;
    auto_clr_next = be_cfg[0] ? bus.wdata[1] : auto_clr;
    irq_en_next   = be_cfg[0] ? bus.wdata[2] : irq_en;

    // A hardware match in the same cycle beats a software clear.
    pend_next = match | (pend & ~(be_cfg[0] & bus.wdata[3]));

    presc_we   = PRESC_W'({{8{be_cfg[2]}}, {8{be_cfg[1]}}});
    presc_next = (presc & ~presc_we) | (bus.wdata[8 +: PRESC_W] & presc_we);
    if (|(be_cfg & PRESC_BYTES)) psc_next = '0;
  end

  // Register the bus response, the interrupt and all timer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_ready <= 1'b0;
      rsp_data  <= '0;
      irq       <= 1'b0;
      en        <= 1'b0;
      auto_clr  <= 1'b0;
      irq_en    <= 1'b0;
      pend      <= 1'b0;
      presc     <= '0;
      psc       <= '0;
      cnt       <= '0;
      compare   <= '0;
    end else begin
      rsp_ready <= hit;
      rsp_data  <= hit ? rd_value : 32'h0;
      irq       <= pend & irq_en;
      en        <= en_next;
      auto_clr  <= auto_clr_next;
      irq_en    <= irq_en_next;
      pend      <= pend_next;
      presc     <= presc_next;
      psc       <= psc_next;
      cnt       <= cnt_next;
      compare   <= compare_next;
    end
  end

  assign bus.ready = rsp_ready;
  assign bus.rdata = rsp_data;

endmodule

// File: tb/tb_soc_timer_responder.sv
// Self-checking bench for soc_timer_responder: a cycle-level reference model
// of the timer register map runs beside the DUT and a compare process checks
// ready, rdata and irq on every falling edge; directed transactions add
// hand-computed literal expectations. Honours TIMER_LATCH_MSB_EN if defined.
module tb_soc_timer_responder;

  localparam logic [31:0] BASE    = 32'h0800_0000;
  localparam logic [31:0] A_CFG   = BASE + 32'h00;
  localparam logic [31:0] A_MSB   = BASE + 32'h08;
  localparam logic [31:0] A_LSB   = BASE + 32'h10;
  localparam logic [31:0] A_SCL   = BASE + 32'h12;
  localparam logic [31:0] A_CMP   = BASE + 32'h20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   tests_run    = 0;
  int   tests_failed = 0;

  soc_timer_responder_if bus_if();

  soc_timer_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_en = 1'b0, m_auto_clr = 1'b0, m_irq_en = 1'b0, m_pend = 1'b0;
  logic [7:0]  m_presc = '0, m_psc = '0;
  logic [63:0] m_cnt = '0;
  logic [31:0] m_cmp = '0, m_shadow = '0, m_rdata = '0;
  logic        m_ready = 1'b0, m_irq = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] actual,
                             input logic [31:0] lo, input logic [31:0] hi);
    tests_run++;
    if (actual < lo || actual > hi) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, actual, lo, hi, $time);
    end
  endtask

  function automatic logic [31:0] patch(input logic [31:0] old_v, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00: return {16'h0, m_presc, 4'h0, m_pend, m_irq_en, m_auto_clr, m_en};
`ifdef TIMER_LATCH_MSB_EN
      8'h08: return m_shadow;
`else
      8'h08: return m_cnt[63:32];
`endif
      8'h10: return m_cnt[31:0];
      8'h12: return {24'h0, m_psc};
      8'h20: return m_cmp;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: one step per rising clock using the inputs held stable there.
  always @(posedge clk or posedge rst) begin : model_step
    logic        acc, tick, hw_set, pend_n;
    logic [7:0]  off, psc_n;
    logic [63:0] cnt_n;
    logic [31:0] rd, cfg_img;
    if (rst) begin
      m_en = 0; m_auto_clr = 0; m_irq_en = 0; m_pend = 0;
      m_presc = 0; m_psc = 0; m_cnt = 0; m_cmp = 0; m_shadow = 0;
      m_ready = 0; m_rdata = 0; m_irq = 0;
    end else begin
      acc = bus_if.valid && ((bus_if.addr & 32'hFFFF_F000) == BASE) && !m_ready;
      off = bus_if.addr[7:0];
      rd  = acc ? model_read(off) : 32'h0;
      m_irq = m_pend & m_irq_en;

      tick = 0; hw_set = 0; psc_n = m_psc; cnt_n = m_cnt;
      if (m_en) begin
        if (m_psc == m_presc) begin tick = 1; psc_n = 0; end
        else psc_n = m_psc + 8'd1;
      end
      if (tick) begin
        if (m_cnt[31:0] == m_cmp) begin
          hw_set = 1;
          cnt_n  = m_auto_clr ? 64'd0 : m_cnt + 64'd1;
        end else begin
          cnt_n = m_cnt + 64'd1;
        end
      end
      pend_n = m_pend | hw_set;

      if (acc && bus_if.wmask == 4'h0 && off == 8'h10) m_shadow = m_cnt[63:32];
      if (acc && bus_if.wmask != 4'h0) begin
        case (off)
          8'h00: begin
            cfg_img    = patch(model_read(8'h00), bus_if.wdata, bus_if.wmask);
            m_en       = cfg_img[0];
            m_auto_clr = cfg_img[1];
            m_irq_en   = cfg_img[2];
            m_presc    = cfg_img[15:8];
            if (bus_if.wmask[1]) psc_n = 0;
            if (bus_if.wmask[0] && bus_if.wdata[3] && !hw_set) pend_n = 0;
          end
          8'h08: begin
            cnt_n[63:32] = patch(cnt_n[63:32], bus_if.wdata, bus_if.wmask);
            m_shadow     = patch(m_shadow, bus_if.wdata, bus_if.wmask);
          end
          8'h10: cnt_n[31:0] = patch(cnt_n[31:0], bus_if.wdata, bus_if.wmask);
          8'h20: m_cmp = patch(m_cmp, bus_if.wdata, bus_if.wmask);
          default: ;
        endcase
      end
      m_cnt = cnt_n; m_psc = psc_n; m_pend = pend_n;
      m_ready = acc; m_rdata = rd;
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    check_output("ready", bus_if.ready, m_ready);
    check_output("irq", irq, m_irq);
    if (m_ready) check_output("rdata", bus_if.rdata, m_rdata);
  end

  // One bus access: present the request, let it be accepted, collect the response.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wmask, output logic [31:0] rdata);
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    bus_if.wmask = wmask;
    @(posedge clk);
    @(negedge clk);
    bus_if.valid = 1'b0;
    bus_if.wmask = 4'h0;
    check_output("ack", bus_if.ready, 1'b1);
    rdata = bus_if.rdata;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] unused_rd;
    apply_stimulus(addr, data, mask, unused_rd);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    apply_stimulus(addr, 32'h0, 4'h0, data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int          pulses;
    logic        seen;
    bus_if.valid = 1'b0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
    bus_if.wmask = 4'h0;

    repeat (3) @(negedge clk);
    check_output("reset_ready", bus_if.ready, 1'b0);
    check_output("reset_irq", irq, 1'b0);
    rst = 1'b0;

    // Reset values and single-cycle ready pulse
    bus_read(A_CFG, v);
    check_output("config_after_reset", v, 32'h0);
    @(negedge clk);
    check_output("ready_one_cycle", bus_if.ready, 1'b0);

    // Prescaled counting: presc=3 gives one tick every 4 cycles
    bus_write(A_CFG, 32'h0000_0301, 4'hF);
    repeat (40) @(negedge clk);
    bus_read(A_LSB, v);
    check_range("lsb_after_40", v, 32'd9, 32'd11);
    bus_read(A_SCL, v);
    check_range("scaled_range", v, 32'd0, 32'd3);

    // Compare with auto-clear and interrupt
    bus_write(A_CFG, 32'h0000_0008, 4'hF);
    bus_write(A_LSB, 32'h0, 4'hF);
    bus_write(A_MSB, 32'h0, 4'hF);
    bus_write(A_CMP, 32'd5, 4'hF);
    check_output("irq_low_before_match", irq, 1'b0);
    bus_write(A_CFG, 32'h0000_0007, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = irq;
    end
    check_output("irq_rise", seen, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus_read(A_LSB, v);
      check_range("lsb_wraps_0_to_5", v, 32'd0, 32'd5);
    end
    bus_write(A_CFG, 32'h0000_000F, 4'hF);
    seen = 1'b1;
    for (int i = 0; i < 10 && seen; i++) begin
      @(negedge clk);
      seen = irq;
    end
    check_output("irq_fall_after_w1c", seen, 1'b0);

    // Carry from the low word into the high word
    bus_write(A_CFG, 32'h0, 4'hF);
    bus_write(A_MSB, 32'h0, 4'hF);
    bus_write(A_LSB, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_CFG, 32'h0000_0001, 4'hF);
    bus_read(A_LSB, v);
    check_output("carry_lsb", v, 32'h0);
    bus_read(A_MSB, v);
    check_output("carry_msb", v, 32'h1);

    // Full 64-bit wrap to zero
    bus_write(A_CFG, 32'h0, 4'hF);
    bus_write(A_MSB, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_LSB, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CFG, 32'h0000_0001, 4'hF);
    repeat (5) @(negedge clk);
    bus_read(A_LSB, v);
    check_output("wrap_lsb", v, 32'd4);
    bus_read(A_MSB, v);
    check_output("wrap_msb", v, 32'h0);

    // Byte-masked writes to COMPARE
    bus_write(A_CFG, 32'h0, 4'hF);
    bus_write(A_CMP, 32'h0, 4'hF);
    bus_write(A_CMP, 32'h0000_AB00, 4'b0010);
    bus_read(A_CMP, v);
    check_output("cmp_byte1", v, 32'h0000_AB00);
    bus_write(A_CMP, 32'hFFFF_FFFF, 4'b0010);
    bus_write(A_CMP, 32'h1234_5678, 4'b1001);
    bus_read(A_CMP, v);
    check_output("cmp_bytes_0_3", v, 32'h1200_FF78);

    // Unmapped offset inside the window
    bus_read(BASE + 32'h44, v);
    check_output("unmapped_read", v, 32'h0);
    bus_write(BASE + 32'h44, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'h44, v);
    check_output("unmapped_after_write", v, 32'h0);

    // Outside the window: never answered
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.addr  = 32'h0900_0000;
    bus_if.wmask = 4'h0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.ready) pulses++;
    end
    bus_if.valid = 1'b0;
    check_output("out_of_window_ready", pulses, 0);

    // Held request: answered every second cycle
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.addr  = A_CMP;
    bus_if.wmask = 4'h0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.ready) pulses++;
    end
    bus_if.valid = 1'b0;
    check_output("held_request_pulses", pulses, 3);

    // Reset in the middle of an access
    bus_write(A_CMP, 32'h55, 4'hF);
    bus_write(A_CFG, 32'h0000_0301, 4'hF);
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.addr  = A_CFG;
    bus_if.wmask = 4'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_output("ready_dropped_by_reset", bus_if.ready, 1'b0);
    @(negedge clk);
    bus_if.valid = 1'b0;
    rst = 1'b0;
    bus_read(A_CFG, v);
    check_output("cfg_after_midreset", v, 32'h0);
    bus_read(A_CMP, v);
    check_output("cmp_after_midreset", v, 32'h0);
    bus_read(A_LSB, v);
    check_output("lsb_after_midreset", v, 32'h0);

    // LSB read, carry, then MSB read
    bus_write(A_MSB, 32'h7, 4'hF);
    bus_write(A_LSB, 32'hFFFF_FFF0, 4'hF);
    bus_write(A_CFG, 32'h0000_0001, 4'hF);
    bus_read(A_LSB, v);
    check_output("latch_lsb", v, 32'hFFFF_FFF1);
    repeat (20) @(negedge clk);
    bus_read(A_MSB, v);
`ifdef TIMER_LATCH_MSB_EN
    check_output("msb_shadow_pre_carry", v, 32'h7);
`else
    check_output("msb_live_post_carry", v, 32'h8);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
